// File: rtl/dbg_uart.sv
// UART debug bridge: 8N1 command bytes from a host become single 16-bit accesses
// on the debugger register window; read data or a write acknowledge goes back over txd.
module dbg_uart #(
    parameter int             l       = 16,
    parameter int             DIV     = 868,
    parameter int             TMO     = 65535,
    parameter logic [l-5:0]   DBGBASE = 12'hFFE
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         rxd,
    output logic         txd,
    output logic         req,
    input  logic         ack,
    output logic [l-2:0] addr,
    output logic         r,
    output logic [1:0]   w,
    output logic [l-1:0] dout,
    input  logic [l-1:0] din,
    output logic         busy
);

    localparam int CW = $clog2(DIV);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_IDLE, P_WHI, P_WLO, P_BUS, P_TX1, P_TX2} p_state_e;

    // ------------------------------------------------------------------
    // rxd synchronizer; the third stage only feeds falling-edge detection
    // ------------------------------------------------------------------
    logic rxd_s1_q, rxd_s2_q, rxd_s3_q;

    // NOTE: every flop resets asynchronously on nreset so a reset mid-frame or
    // mid-access drops req/r/w at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_stb, rx_ferr, rx_tick;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // NOTE: each always_comb assigns every output a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_stb     = 1'b0;
        rx_ferr    = 1'b0;
        rx_tick    = (rx_cnt_q == BIT_LAST);
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rxd_s3_q && !rxd_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    // Line back high at mid start bit: treat as a glitch
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_stb     = rxd_s2_q;
                    rx_ferr    = !rxd_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter: a start request wins over the end of the previous stop
    // bit, so consecutive reply bytes run back to back.
    // ------------------------------------------------------------------
    logic          tx_active_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_shift_q;
    logic          txd_q;
    logic          tx_start, tx_done;
    logic [7:0]    tx_byte;

    assign tx_done = tx_active_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
        end else if (tx_start) begin
            tx_active_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= {1'b1, tx_byte};
            txd_q       <= 1'b0;
        end else if (tx_active_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_active_q <= 1'b0;
                    txd_q       <= 1'b1;
                end else begin
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    p_state_e      p_state_q, p_state_d;
    logic          we_q, we_d;
    logic [2:0]    idx_q, idx_d;
    logic [l-2:0]  addr_q, addr_d;
    logic [l-1:0]  dout_q, dout_d;
    logic [7:0]    reply_q, reply_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            p_state_q <= P_IDLE;
            we_q      <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            reply_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            p_state_q <= p_state_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            reply_q   <= reply_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        we_d      = we_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        reply_d   = reply_q;
        tmo_cnt_d = '0;
        tx_start  = 1'b0;
        tx_byte   = reply_q;
        unique case (p_state_q)
            P_IDLE: begin
                if (rx_stb && (rx_shift_q[6:3] == 4'd0)) begin
                    we_d  = rx_shift_q[7];
                    idx_d = rx_shift_q[2:0];
                    if (rx_shift_q[7]) begin
                        p_state_d = P_WHI;
                    end else begin
                        p_state_d = P_BUS;
                        addr_d    = {DBGBASE, rx_shift_q[2:0]};
                    end
                end
            end
            P_WHI, P_WLO: begin
                // A byte in the same cycle as the timeout still counts
                if (rx_stb) begin
                    if (p_state_q == P_WHI) begin
                        dout_d[l-1:l-8] = rx_shift_q;
                        p_state_d       = P_WLO;
                    end else begin
                        dout_d[7:0] = rx_shift_q;
                        addr_d      = {DBGBASE, idx_q};
                        p_state_d   = P_BUS;
                    end
                end else if (rx_ferr || (tmo_cnt_q == TMO_LAST)) begin
                    p_state_d = P_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            P_BUS: begin
                if (ack) begin
                    tx_start = 1'b1;
                    if (we_q) begin
                        reply_d   = 8'h06;
                        tx_byte   = 8'h06;
                        p_state_d = P_TX2;
                    end else begin
                        reply_d   = din[7:0];
                        tx_byte   = din[l-1:l-8];
                        p_state_d = P_TX1;
                    end
                end
            end
            P_TX1: begin
                if (tx_done) begin
                    tx_start  = 1'b1;
                    p_state_d = P_TX2;
                end
            end
            P_TX2: begin
                if (tx_done) p_state_d = P_IDLE;
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    assign req  = (p_state_q == P_BUS);
    assign r    = req && !we_q;
    assign w    = {2{req && we_q}};
    assign addr = addr_q;
    assign dout = dout_q;
    assign txd  = txd_q;
    assign busy = (p_state_q != P_IDLE);

endmodule

// File: tb/tb_dbg_uart.sv
// Scoreboard bench for dbg_uart: reply bytes are queued when the bus access is
// granted and popped by a UART decoder watching txd.
module tb_dbg_uart;

    localparam int DIV = 4;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        nreset;
    logic        rxd;
    logic        txd;
    logic        req;
    logic        ack;
    logic [14:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dout;
    logic [15:0] din;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          req_hi = 0;
    int          req_rise = 0;
    logic        req_prev = 1'b0;

    dbg_uart #(.l(16), .DIV(DIV), .TMO(TMO), .DBGBASE(12'hFFE)) dut (
        .clk    (clk),
        .nreset (nreset),
        .rxd    (rxd),
        .txd    (txd),
        .req    (req),
        .ack    (ack),
        .addr   (addr),
        .r      (r),
        .w      (w),
        .dout   (dout),
        .din    (din),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req === 1'b1) req_hi++;
        if (req === 1'b1 && req_prev !== 1'b1) req_rise++;
        req_prev = req;
    end

    // txd decoder: pops the scoreboard for every completed frame
    initial begin
        logic [7:0] b;
        logic       stop;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (nreset === 1'b1 && txd === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                stop = txd;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %02h, none expected", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e || stop !== 1'b1) begin
                        n_err++;
                        $display("FAIL tx_byte: got %02h stop %b, want %02h stop 1", b, stop, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic expect_busy(input string name, input logic want);
        n_vec++;
        if (busy !== want) begin
            n_err++;
            $display("FAIL %s: busy got %b want %b", name, busy, want);
        end
    endtask

    // Arbiter model: wait for req, check the access, grant after dly cycles
    task automatic bus_cycle(input string name, input logic [14:0] ea, input logic er,
                             input logic [1:0] ew, input logic [15:0] ed,
                             input int dly, input logic [15:0] dv);
        int t = 0;
        while (req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL %s_req: req got %b want 1 within 300 cycles", name, req);
            return;
        end
        n_vec++;
        if (addr !== ea || r !== er || w !== ew) begin
            n_err++;
            $display("FAIL %s_bus: addr %h r %b w %b, want addr %h r %b w %b",
                     name, addr, r, w, ea, er, ew);
        end
        if (ew == 2'b11) begin
            n_vec++;
            if (dout !== ed) begin
                n_err++;
                $display("FAIL %s_dout: got %h want %h", name, dout, ed);
            end
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(dv[15:8]);
            exp_q.push_back(dv[7:0]);
        end
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            n_vec++;
            if (req !== 1'b1 || addr !== ea || r !== er || w !== ew) begin
                n_err++;
                $display("FAIL %s_hold: req %b addr %h r %b w %b", name, req, addr, r, w);
            end
        end
        din = dv;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        din = 16'($urandom);
        n_vec++;
        if (req !== 1'b0 || r !== 1'b0 || w !== 2'b00 || txd !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after_ack: req %b r %b w %b txd %b, want 0 0 00 0",
                     name, req, r, w, txd);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        nreset = 1'b0;
        rxd    = 1'b1;
        ack    = 1'b0;
        din    = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (txd !== 1'b1 || req !== 1'b0 || r !== 1'b0 || w !== 2'b00 ||
            busy !== 1'b0 || addr !== 15'h0 || dout !== 16'h0) begin
            n_err++;
            $display("FAIL reset_values: txd %b req %b r %b w %b busy %b addr %h dout %h",
                     txd, req, r, w, busy, addr, dout);
        end
        nreset = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || req !== 1'b0 || w !== 2'b00 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_idle: %0d cycles with changed outputs, want 0", bad);
        end
    endtask

    task automatic test_read();
        send_byte(8'h05, 1'b1);
        bus_cycle("read", 15'h7FF5, 1'b1, 2'b00, 16'h0, 3, 16'hBEEF);
        repeat (77) @(negedge clk);
        expect_busy("read_busy_in_tx", 1'b1);
        repeat (4) @(negedge clk);
        expect_busy("read_busy_done", 1'b0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL read_reply: %0d bytes outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_write();
        send_byte(8'h84, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        bus_cycle("write", 15'h7FF4, 1'b0, 2'b11, 16'h1234, 3, 16'($urandom));
        repeat (44) @(negedge clk);
        expect_busy("write_busy_done", 1'b0);
    endtask

    task automatic test_timeout();
        int rises = req_rise;
        send_byte(8'h86, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (5) @(negedge clk);
        expect_busy("timeout_partial", 1'b1);
        repeat (245) @(negedge clk);
        expect_busy("timeout_expired", 1'b0);
        n_vec++;
        if (req_rise != rises) begin
            n_err++;
            $display("FAIL timeout_req: %0d req pulses, want 0", req_rise - rises);
        end
        send_byte(8'h03, 1'b1);
        bus_cycle("timeout_read", 15'h7FF3, 1'b1, 2'b00, 16'h0, 1, 16'hA55A);
        repeat (85) @(negedge clk);
        expect_busy("timeout_read_done", 1'b0);
    endtask

    task automatic test_errors();
        int hi = req_hi;
        send_byte(8'h48, 1'b1);
        repeat (20) @(negedge clk);
        expect_busy("reserved_ignored", 1'b0);
        send_byte(8'h84, 1'b1);
        repeat (2) @(negedge clk);
        expect_busy("whi_entered", 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (5) @(negedge clk);
        expect_busy("framing_idle", 1'b0);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        expect_busy("glitch_idle", 1'b0);
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        repeat (5) @(negedge clk);
        expect_busy("stray_ack", 1'b0);
        n_vec++;
        if (req_hi != hi) begin
            n_err++;
            $display("FAIL errors_req: req high %0d cycles, want 0", req_hi - hi);
        end
        // Glitch while collecting write data must not consume a data byte
        send_byte(8'h87, 1'b1);
        repeat (10) @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        bus_cycle("glitch_write", 15'h7FF7, 1'b0, 2'b11, 16'h1234, 2, 16'h0);
        repeat (44) @(negedge clk);
        expect_busy("glitch_write_done", 1'b0);
    endtask

    task automatic test_ack_same_cycle();
        int hi = req_hi;
        din = 16'h1357;
        ack = 1'b1;
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h57);
        send_byte(8'h02, 1'b1);
        repeat (20) @(negedge clk);
        ack = 1'b0;
        n_vec++;
        if (req_hi - hi != 1) begin
            n_err++;
            $display("FAIL ack_same_cycle: req high %0d cycles, want 1", req_hi - hi);
        end
        repeat (70) @(negedge clk);
        expect_busy("ack_same_cycle_done", 1'b0);
    endtask

    task automatic test_reset_mid_access();
        int t = 0;
        int hi;
        send_byte(8'h01, 1'b1);
        while (req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_req: req got %b want 1", req);
        end
        nreset = 1'b0;
        #1;
        n_vec++;
        if (req !== 1'b0 || r !== 1'b0 || w !== 2'b00 || busy !== 1'b0 || txd !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_async: req %b r %b w %b busy %b txd %b, want 0 0 00 0 1",
                     req, r, w, busy, txd);
        end
        @(negedge clk);
        nreset = 1'b1;
        hi = req_hi;
        repeat (100) @(negedge clk);
        n_vec++;
        if (req_hi != hi || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_after: req cycles %0d busy %b, want 0 0", req_hi - hi, busy);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_errors();
        test_ack_same_cycle();
        test_reset_mid_access();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_scoreboard: %0d replies never seen", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_uart.md
# dbg_uart

Serial debug bridge for the b16 core. Receives 8N1 UART command bytes from a host, turns them into single 16-bit accesses on the debugger register window (word addresses 0xFFE0–0xFFEE), and returns read data or a write acknowledge over UART. It is the bus master that drives the debugger's `addr/r/w/data` inputs. It shares the memory bus with the CPU through a req/ack arbiter.

## Interface

Parameters:
- `l`, 16: data width.
- `DIV`, 868: clock cycles per UART bit, ≥ 4.
- `TMO`, 65535: inter-byte timeout in clock cycles for a partially received command.
- `DBGBASE`, 12'hFFE: value driven on `addr[l-1:4]`.

Ports:
- `clk`, in, 1: clock.
- `nreset`, in, 1: reset, asynchronous, active-low.
- `rxd`, in, 1: UART receive line, asynchronous, idle high.
- `txd`, out, 1: UART transmit line, idle high.
- `req`, out, 1: bus request to the arbiter.
- `ack`, in, 1: one-cycle grant/complete strobe from the arbiter.
- `addr`, out, l-1: word address `[l-1:1]`, equal to `{DBGBASE, idx[2:0]}`.
- `r`, out, 1: read strobe. Valid only while `req`.
- `w`, out, 2: byte-lane write strobes `{hi, lo}`. Valid only while `req`.
- `dout`, out, l: write data.
- `din`, in, l: read data. Sampled on the `ack` cycle.
- `busy`, out, 1: high whenever the parser is not in IDLE.

## Operation

Receiver:
- `rxd` passes through a 2-flop synchronizer.
- A falling edge starts the bit timer. `rxd` is resampled at DIV/2. If it is high, the edge was a false start and the receiver returns to idle.
- Data bits are sampled every DIV cycles, LSB first.
- The stop bit is sampled at 9.5·DIV.
  - Stop bit = 1: the byte is valid, and a 1-cycle `rx_stb` fires.
  - Stop bit = 0: framing error. The byte is dropped and the parser is forced to IDLE.

Command byte:
- bit7 W: 1 = write, 0 = read.
- bits6:3: must be 0. A nonzero value makes the byte ignored; the parser stays in IDLE.
- bits2:0 idx: selects the debugger register.

Parser FSM:
- IDLE: a valid command byte latches W and idx.
  - Read → BUS.
  - Write → WHI.
- WHI: the next byte goes to `dout[15:8]` → WLO.
- WLO: the next byte goes to `dout[7:0]` → BUS.
- BUS: `req`=1, `addr={DBGBASE,idx}`, and either `r`=1, `w`=00 (read) or `r`=0, `w`=11 (write). All outputs hold until the cycle in which `ack`=1.
  - On `ack`: a read captures `din` into the reply register, then → TX1.
  - On `ack`: a write loads the reply with 0x06, then → TX2.
  - The cycle after `ack`: `req`, `r` and `w` are all 0.
- TX1: transmit reply[15:8] → TX2.
- TX2: transmit reply[7:0] for a read, or 0x06 for a write → IDLE.

Transmitter:
- 8N1 format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIV cycles, so a frame is 10·DIV cycles.
- The next reply byte starts the cycle after the previous stop bit ends.

Inter-byte timeout:
- In WHI and WLO, a counter reloads on every `rx_stb`.
- If TMO cycles pass with no byte, the parser returns to IDLE and the partial command is discarded. No reply is sent.

Bytes received while in BUS, TX1 or TX2 are discarded. The receiver keeps running so it stays in frame sync.

`busy` is 1 in every state except IDLE.

## Timing

Reset values:
- `txd`=1, `req`=0, `r`=0, `w`=00, `addr`=0, `dout`=0, `busy`=0.
- Parser in IDLE, receiver and transmitter idle, all counters 0.
- Reset asserted mid-frame or mid-bus-cycle aborts immediately to these values. No partial UART frame is completed.

Latencies:
- `rx_stb` fires 2 + 9.5·DIV cycles (±1) after the `rxd` falling edge.
- `req` rises the cycle after the `rx_stb` that completes the command.
- `txd` start bit begins the cycle after `ack`.

Edge cases:
- `ack` while `req`=0 is ignored.
- `ack` in the same cycle `req` rises completes the access; minimum bus occupancy is one cycle.
- A framing error during WHI or WLO resets the parser to IDLE. A framing error during BUS, TX1 or TX2 does not disturb the access or the reply.
- Timeout and `rx_stb` in the same cycle: `rx_stb` wins and the byte is accepted.
- All counters are sized to their parameters and saturate or wrap only at their terminal value (DIV-1, TMO).

## Test plan

Use DIV=4 and TMO=200 throughout.

1. Reset: hold `nreset`=0 → `txd`=1, `req`=0, `w`=00, `busy`=0. Release, send nothing for 1000 cycles → outputs unchanged.
2. Read: send 0x05, arbiter acks 3 cycles after `req`, `din`=0xBEEF → `addr`=0x7FF5 with `r`=1 until `ack`; `txd` then sends 0xBE, 0xEF; `busy` falls after the second stop bit.
3. Write: send 0x84, 0x12, 0x34 → `req` with `w`=11, `dout`=0x1234, `addr`=0x7FF4 held until `ack`; reply 0x06.
4. Timeout: send 0x86, 0xAA, then idle 250 cycles → no `req`, `busy`=0; a following 0x03 read completes normally.
5. Errors: send 0x48 (reserved bits set) → ignored. Send a frame with stop bit 0 during WHI → parser returns to IDLE. A 1-cycle low glitch on `rxd` → no byte received.
6. Reset mid-access: assert `nreset` while `req`=1 before `ack` → `req`, `r` and `w` drop asynchronously and no reply is transmitted.
